// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution front end: kernel geometry, tap
// indices (row-major, 00 = top-left) and the counter-width helper.
package conv_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int KERNEL_DIM     = 3;
  localparam int KERNEL_TAPS    = KERNEL_DIM * KERNEL_DIM;

  localparam int TAP_00 = 0;
  localparam int TAP_01 = 1;
  localparam int TAP_02 = 2;
  localparam int TAP_03 = 3;
  localparam int TAP_04 = 4;
  localparam int TAP_05 = 5;
  localparam int TAP_06 = 6;
  localparam int TAP_07 = 7;
  localparam int TAP_08 = 8;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay: enable-gated shift register whose single tap is the
// pixel accepted DEPTH beats ago (visible before the shift on the next beat).
module conv_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] tap_o
);

  logic [DATA_WIDTH-1:0] sr_q [DEPTH];

  // NOTE: storage arrays are deliberately not reset; their stale contents only
  // ever reach windows that the valid flag masks, and skipping the reset lets
  // the row map onto plain RAM/SRL resources.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      sr_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign tap_o = sr_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two chained line buffers feed a 3x3 tap array.
// Optional build macro CONV_WINDOW_FRAME_CNT_EN adds an 8-bit frame counter output.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst,
  input  logic                  in_Valid,
  input  logic                  in_Sof,
  input  logic [DATA_WIDTH-1:0] in_Pixel,
  output logic [DATA_WIDTH-1:0] out_Pix_00,
  output logic [DATA_WIDTH-1:0] out_Pix_01,
  output logic [DATA_WIDTH-1:0] out_Pix_02,
  output logic [DATA_WIDTH-1:0] out_Pix_03,
  output logic [DATA_WIDTH-1:0] out_Pix_04,
  output logic [DATA_WIDTH-1:0] out_Pix_05,
  output logic [DATA_WIDTH-1:0] out_Pix_06,
  output logic [DATA_WIDTH-1:0] out_Pix_07,
  output logic [DATA_WIDTH-1:0] out_Pix_08,
  output logic                  out_Valid,
`ifdef CONV_WINDOW_FRAME_CNT_EN
  output logic [7:0]            out_Frame_Cnt,
`endif
  output logic                  out_Frame_Done
);

  localparam int CW = cnt_width(IMG_WIDTH);
  localparam int RW = cnt_width(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]         col_q, col_d, eff_col;
  logic [RW-1:0]         row_q, row_d, eff_row;
  logic [DATA_WIDTH-1:0] win_q [KERNEL_TAPS];
  logic [DATA_WIDTH-1:0] win_d [KERNEL_TAPS];
  logic [DATA_WIDTH-1:0] lb0_tap, lb1_tap;
  logic                  valid_q, valid_d, done_q, done_d;

  conv_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb0 (
    .clk_i (in_Clk),
    .en_i  (in_Valid),
    .din_i (in_Pixel),
    .tap_o (lb0_tap)
  );

  conv_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
    .clk_i (in_Clk),
    .en_i  (in_Valid),
    .din_i (lb0_tap),
    .tap_o (lb1_tap)
  );

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    eff_col = in_Sof ? '0 : col_q;
    eff_row = in_Sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (in_Valid) begin
      valid_d = (eff_row >= RW'(2)) && (eff_col >= CW'(2));
      done_d  = (eff_row == ROW_LAST) && (eff_col == COL_LAST);
      if (eff_col == COL_LAST) begin
        col_d = '0;
        row_d = (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
      end else begin
        col_d = eff_col + CW'(1);
        row_d = eff_row;
      end
      for (int i = 0; i < KERNEL_DIM; i++) begin
        win_d[KERNEL_DIM*i]     = win_q[KERNEL_DIM*i + 1];
        win_d[KERNEL_DIM*i + 1] = win_q[KERNEL_DIM*i + 2];
      end
      // Newest column: two rows back, one row back, current pixel.
      win_d[TAP_02] = lb1_tap;
      win_d[TAP_05] = lb0_tap;
      win_d[TAP_08] = in_Pixel;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all
  // registers sample their _d values from the same pre-edge snapshot.
  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < KERNEL_TAPS; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

`ifdef CONV_WINDOW_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = frame_cnt_q + (done_d ? 8'd1 : 8'd0);

  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign out_Frame_Cnt = frame_cnt_q;
`endif

  assign out_Pix_00     = win_q[TAP_00];
  assign out_Pix_01     = win_q[TAP_01];
  assign out_Pix_02     = win_q[TAP_02];
  assign out_Pix_03     = win_q[TAP_03];
  assign out_Pix_04     = win_q[TAP_04];
  assign out_Pix_05     = win_q[TAP_05];
  assign out_Pix_06     = win_q[TAP_06];
  assign out_Pix_07     = win_q[TAP_07];
  assign out_Pix_08     = win_q[TAP_08];
  assign out_Valid      = valid_q;
  assign out_Frame_Done = done_q;

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 window generator that feeds the convolution datapath. It accepts one raster-order pixel per valid beat, keeps the two previous image rows in line buffers, and presents the nine pixels of the current 3x3 neighbourhood in parallel to the multiplier stage. That stage's nine products go to the 9-input adder/clamp. Only windows lying fully inside the image are flagged valid; there is no border padding.

## Interface
- DATA_WIDTH, 8: pixel width in bits.
- IMG_WIDTH, 32: pixels per row; must be at least 3.
- IMG_HEIGHT, 32: rows per frame; must be at least 3.

Ports:
- in_Clk  input  1  the only clock; all state updates on the rising edge.
- in_Rst  input  1  reset, asynchronous and active-high.
- in_Valid  input  1  in_Pixel is valid this cycle (one accepted beat).
- in_Sof  input  1  start of frame; qualified by in_Valid.
- in_Pixel  input  DATA_WIDTH  input pixel, raster order.
- out_Pix_00 … out_Pix_08  output  DATA_WIDTH each  window taps, row-major, 00 = top-left, 08 = bottom-right (newest pixel).
- out_Valid  output  1  window taps form a complete in-image window.
- out_Frame_Done  output  1  one-cycle pulse, coincident with the last window of a frame.

## Operation
- Internal column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) index the pixel accepted on each in_Valid beat.
- Accepted beat at (row, col):
  - The pixel shifts into the bottom window row; line buffer 0 is output-tapped for the middle row and line buffer 1 for the top row.
  - Both line buffers advance by one.
  - col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
- Window contents after the beat at (r, c): out_Pix_(3i+j) = pixel(r-2+i, c-2+j), for i, j in 0..2.
- out_Valid = 1 for that window iff r ≥ 2 and c ≥ 2. Each frame therefore produces (IMG_HEIGHT-2)·(IMG_WIDTH-2) valid windows.
- At row = IMG_HEIGHT-1 and col = IMG_WIDTH-1:
  - out_Frame_Done pulses with out_Valid.
  - row and col both return to 0.
- in_Sof with in_Valid = 1 forces the beat to be treated as (0,0): counters restart, and the pixel lands at col 0. The line buffers are not cleared; stale data sits only behind invalid windows.
- in_Sof with in_Valid = 0 is ignored.
- Cycles without in_Valid:
  - no state advances;
  - taps hold their last values;
  - out_Valid and out_Frame_Done are 0.
- Taps from columns 0/1 contain wrapped previous-row data; out_Valid masks these windows.

## Timing
- Latency: taps, out_Valid and out_Frame_Done are registered and appear the cycle after the accepting edge.
- Throughput: one pixel per cycle, with no stall or back-pressure. The upstream source owns pacing through in_Valid gaps.
- Reset values:
  - all out_Pix_xx = 0;
  - out_Valid = 0, out_Frame_Done = 0;
  - row = col = 0.
- Line buffer contents are not reset.
- in_Rst asserted mid-frame: outputs are cleared asynchronously, and the next in_Valid beat after release is pixel (0,0).

## Configuration
- Macro CONV_WINDOW_FRAME_CNT_EN.
- Defined:
  - adds output out_Frame_Cnt, 8 bits, reset 0;
  - it increments on every out_Frame_Done and wraps 255 → 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

## Structure
- Shared package conv_pkg holds:
  - DATA_WIDTH default;
  - KERNEL_TAPS = 9 and KERNEL_DIM = 3;
  - tap index constants;
  - a clog2-based counter-width helper used for col/row.
- One sub-module, conv_line_buffer: an enable-gated shift register of depth IMG_WIDTH × DATA_WIDTH with a single output tap. It is instantiated twice and chained.
- The window registers and counters live in conv_window_gen.

## Test plan
- 4×4 frame, pixel = 4·row + col + 1, continuous in_Valid:
  - first valid window is 1,2,3,5,6,7,9,10,11, one cycle after pixel 11;
  - exactly 4 valid windows;
  - last window is 6,7,8,10,11,12,14,15,16, with out_Frame_Done = 1.
- Same frame with in_Valid deasserted every other cycle → identical window sequence; out_Valid is never high on an idle cycle.
- Two back-to-back 4×4 frames, second frame's pixels offset by +100 → the second frame's first window is 101,102,103,105,…,111.
- Mid-frame in_Sof at (2,1) followed by a fresh 4×4 frame → no valid window until the new pixel (2,2); then 4 windows with correct values.
- in_Rst pulsed after pixel 9:
  - all outputs read 0 immediately;
  - a following full frame yields exactly 4 correct windows.
- With CONV_WINDOW_FRAME_CNT_EN defined and 257 frames of 3×3 → out_Frame_Cnt = 1, with one window per frame.
